muldiv_ctrl: RTL
================

# muldiv_ctrl

Controller for the HI/LO multiply/divide resource behind the execute stage. It accepts the mult/div/mfhi/mflo/mthi/mtlo class of operations decoded in ID as `alu_op[19:12]`. It sequences a pipelined multiplier and an iterative radix-2 divider, and owns the HI/LO registers. It stalls the execute stage whenever the resource is busy.

## Interface
Parameters:
- MUL_LAT, 2, multiplier cycles between acceptance and HI/LO write (1..4)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  execute stage holds a valid muldiv-class op
- req_op  in  8  one-hot {mtlo,mthi,mflo,mfhi,divu,div,multu,mult}, bit order identical to `alu_op[19:12]`
- req_src1  in  32  rs value (dividend / multiplicand / mthi/mtlo data)
- req_src2  in  32  rt value (divisor / multiplier)
- cancel  in  1  flush: discard any in-flight op and refuse new ones this cycle
- req_ready  out  1  op accepted this cycle
- es_stall  out  1  req_valid & ~req_ready
- mf_rdata  out  32  HI (mfhi) or LO (mflo), valid combinationally in the accept cycle
- busy  out  1  a mult/div is in flight

## Operation
- The FSM has four states: IDLE, MUL, DIV, FIX.
- req_ready = (state==IDLE) & ~cancel. All op classes, including mf/mt, are accepted only in IDLE. Any op issued while busy stalls.
- **mthi / mtlo:** HI (or LO) ← req_src1 at the accept edge. The state stays IDLE.
- **mfhi / mflo:** mf_rdata = the current HI/LO register. The state stays IDLE. mf_rdata = 0 when no mf op is presented.
- **mult / multu:** full 64-bit signed or unsigned product, piped through MUL_LAT register stages.
  - IDLE→MUL on accept.
  - At the end of the last MUL cycle: {HI,LO} ← product, then MUL→IDLE.
- **div / divu:** restoring division on magnitudes.
  - Operands are latched on accept; IDLE→DIV.
  - DIV runs 32 iterations under a 6-bit counter, then DIV→FIX.
  - FIX applies the sign rules below, writes LO ← quotient and HI ← remainder, then FIX→IDLE.
  - Signed quotient is negated when the operand signs differ. Signed remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0, both div and divu: LO=0xFFFFFFFF, HI=req_src1. This is forced in FIX.
- **cancel:** in MUL/DIV/FIX the next state is IDLE and HI/LO are not written. If cancel falls in the write cycle, the write is suppressed. In IDLE, cancel blocks acceptance.
- **Reset:** state=IDLE, HI=LO=0, counter=0, pipeline valid bits cleared. Reset mid-operation aborts without writing HI/LO.
- **Illegal req_op:** zero or multiple bits set with req_valid high → accepted and treated as a no-op.

## Timing
- Accept edge = end of cycle 0.
- **mult:**
  - busy=1 in cycles 1..MUL_LAT.
  - HI/LO written at the end of cycle MUL_LAT.
  - IDLE and updated HI/LO visible in cycle MUL_LAT+1.
- **div:**
  - DIV in cycles 1..32, FIX in cycle 33, busy=1 throughout.
  - New HI/LO visible in cycle 34.
- An mf/mt/mult/div presented in cycle 1 stalls until the first IDLE cycle and is accepted then. This covers back-to-back ops.
- mthi/mtlo writes at the accept edge. An mfhi/mflo in the following cycle sees the new value.
- Outputs at reset: req_ready=1 (cancel low), es_stall=0, busy=0, mf_rdata=0.

## Structure
- In `mycpu.h`:
  - `MD_OP_*` bit indices for req_op.
  - `MD_ST_*` state encodings (2-bit).
  - `MD_OP_WD`=8.
- One sub-module, `div_iter`: operand latch, 32-step restore/shift loop, and iteration counter, with start/done/cancel ports.
- The multiplier is an inline `*` followed by MUL_LAT register stages.
- Sign fix-up and the FSM live in muldiv_ctrl.

## Test plan
1. **Reset state:** assert reset, then issue mfhi and mflo → mf_rdata=0 for both, req_ready=1, busy=0.
2. **Multiply:**
   - mult 0xFFFFFFFF × 0x00000002 → HI=0xFFFFFFFF, LO=0xFFFFFFFE.
   - multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
   - mflo issued in cycle 1 → es_stall high exactly MUL_LAT cycles, then returns 0xFFFFFFFE.
3. **Signed divide:**
   - div 0xFFFFFFF9 / 2 (−7/2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - busy high exactly 33 cycles.
   - divu 100/7 → LO=14, HI=2.
4. **Boundary divides:**
   - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
   - divu 5 / 0 → LO=0xFFFFFFFF, HI=5.
5. **Cancel:**
   - HI/LO preloaded to 0xA/0xB, cancel at DIV cycle 10 → busy=0 in cycle 11, HI/LO still 0xA/0xB.
   - cancel with mthi in IDLE → not accepted, HI unchanged.
   - reset asserted mid-mult → HI=LO=0.
6. **Move-to:**
   - mthi 0x12345678 then mfhi in the next cycle → 0x12345678.
   - mtlo issued during a div → stalls until cycle 34, then LO is overwritten after the divide result.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared op-bit indices, FSM encodings and helpers for the HI/LO multiply/divide controller.
package muldiv_ctrl_pkg;

    localparam int unsigned MD_OP_WD    = 8;
    localparam int unsigned MD_OP_MULT  = 0;
    localparam int unsigned MD_OP_MULTU = 1;
    localparam int unsigned MD_OP_DIV   = 2;
    localparam int unsigned MD_OP_DIVU  = 3;
    localparam int unsigned MD_OP_MFHI  = 4;
    localparam int unsigned MD_OP_MFLO  = 5;
    localparam int unsigned MD_OP_MTHI  = 6;
    localparam int unsigned MD_OP_MTLO  = 7;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_MUL  = 2'd1,
        MD_ST_DIV  = 2'd2,
        MD_ST_FIX  = 2'd3
    } md_state_e;

    // Magnitude of a 32-bit operand; 0x80000000 stays 0x80000000 as an unsigned value.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> muldiv controller request/response bundle.
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic                req_valid;
    logic [MD_OP_WD-1:0] req_op;
    logic [31:0]         req_src1;
    logic [31:0]         req_src2;
    logic                cancel;
    logic                req_ready;
    logic                es_stall;
    logic [31:0]         mf_rdata;
    logic                busy;

    modport master (
        output req_valid, req_op, req_src1, req_src2, cancel,
        input  req_ready, es_stall, mf_rdata, busy
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, cancel,
        output req_ready, es_stall, mf_rdata, busy
    );

endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// Iterative radix-2 restoring divider on 32-bit magnitudes (the div_iter unit).
module muldiv_ctrl_div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        done
);

    logic [31:0] quot_q, rem_q, dvs_q;
    logic [5:0]  cnt;
    logic        running;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] sub;

    assign shifted = {rem_q, quot_q[31]};
    assign ge      = shifted >= {1'b0, dvs_q};
    // Modulo-2^32 is exact here: when ge holds the true difference is below the divisor.
    assign sub     = shifted[31:0] - dvs_q;
    assign done    = running && (cnt == 6'd31);
    assign quot    = quot_q;
    assign rem     = rem_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= 6'd0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
            dvs_q   <= 32'd0;
        end else if (cancel) begin
            running <= 1'b0;
            cnt     <= 6'd0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= 6'd0;
            quot_q  <= dividend;
            rem_q   <= 32'd0;
            dvs_q   <= divisor;
        end else if (running) begin
            cnt    <= cnt + 6'd1;
            rem_q  <= ge ? sub : shifted[31:0];
            quot_q <= {quot_q[30:0], ge};
            if (done) running <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: pipelined multiplier, iterative divider, stall generation.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave bus
);

    md_state_e   state;
    logic [31:0] hi, lo;
    logic        op_legal, accept;
    logic        is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo;

    assign op_legal = $onehot(bus.req_op);
    assign is_mult  = op_legal & bus.req_op[MD_OP_MULT];
    assign is_multu = op_legal & bus.req_op[MD_OP_MULTU];
    assign is_div   = op_legal & bus.req_op[MD_OP_DIV];
    assign is_divu  = op_legal & bus.req_op[MD_OP_DIVU];
    assign is_mfhi  = op_legal & bus.req_op[MD_OP_MFHI];
    assign is_mflo  = op_legal & bus.req_op[MD_OP_MFLO];
    assign is_mthi  = op_legal & bus.req_op[MD_OP_MTHI];
    assign is_mtlo  = op_legal & bus.req_op[MD_OP_MTLO];

    assign bus.req_ready = (state == MD_ST_IDLE) & ~bus.cancel;
    assign accept        = bus.req_valid & bus.req_ready;
    assign bus.es_stall  = bus.req_valid & ~bus.req_ready;
    assign bus.busy      = (state != MD_ST_IDLE);

    always_comb begin
        bus.mf_rdata = 32'd0;
        if (bus.req_valid && is_mfhi)      bus.mf_rdata = hi;
        else if (bus.req_valid && is_mflo) bus.mf_rdata = lo;
    end

    // Multiplier: sign/zero extend to 64 bits so one multiply serves mult and multu.
    logic [63:0]        mul_a, mul_b, product;
    logic [63:0]        mul_pipe [MUL_LAT];
    logic [MUL_LAT-1:0] mul_vld, mul_vld_d;

    assign mul_a   = {{32{is_mult & bus.req_src1[31]}}, bus.req_src1};
    assign mul_b   = {{32{is_mult & bus.req_src2[31]}}, bus.req_src2};
    assign product = mul_a * mul_b;

    always_comb begin
        mul_vld_d    = mul_vld << 1;
        mul_vld_d[0] = accept & (is_mult | is_multu);
    end

    always_ff @(posedge clk) begin
        if (reset || bus.cancel) mul_vld <= '0;
        else                     mul_vld <= mul_vld_d;
        mul_pipe[0] <= product;
        for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end

    // Divider and sign fix-up.
    logic [31:0] div_quot, div_rem, div_src1;
    logic        div_done, neg_q, neg_r, div_zero;
    logic [31:0] fix_hi, fix_lo;

    muldiv_ctrl_div_iter u_div_iter (
        .clk      (clk),
        .reset    (reset),
        .start    (accept & (is_div | is_divu)),
        .cancel   (bus.cancel),
        .dividend (md_abs(bus.req_src1, is_div)),
        .divisor  (md_abs(bus.req_src2, is_div)),
        .quot     (div_quot),
        .rem      (div_rem),
        .done     (div_done)
    );

    always_comb begin
        fix_lo = neg_q ? (~div_quot + 32'd1) : div_quot;
        fix_hi = neg_r ? (~div_rem + 32'd1) : div_rem;
        if (div_zero) begin
            fix_lo = 32'hFFFF_FFFF;
            fix_hi = div_src1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MD_ST_IDLE;
            hi       <= 32'd0;
            lo       <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            div_src1 <= 32'd0;
        end else begin
            case (state)
                MD_ST_IDLE: begin
                    if (accept) begin
                        if (is_mthi) hi <= bus.req_src1;
                        if (is_mtlo) lo <= bus.req_src1;
                        if (is_mult || is_multu) state <= MD_ST_MUL;
                        if (is_div || is_divu) begin
                            state    <= MD_ST_DIV;
                            neg_q    <= is_div & (bus.req_src1[31] ^ bus.req_src2[31]);
                            neg_r    <= is_div & bus.req_src1[31];
                            div_zero <= (bus.req_src2 == 32'd0);
                            div_src1 <= bus.req_src1;
                        end
                    end
                end
                MD_ST_MUL: begin
                    if (bus.cancel) begin
                        state <= MD_ST_IDLE;
                    end else if (mul_vld[MUL_LAT-1]) begin
                        {hi, lo} <= mul_pipe[MUL_LAT-1];
                        state    <= MD_ST_IDLE;
                    end
                end
                MD_ST_DIV: begin
                    if (bus.cancel)    state <= MD_ST_IDLE;
                    else if (div_done) state <= MD_ST_FIX;
                end
                MD_ST_FIX: begin
                    state <= MD_ST_IDLE;
                    if (!bus.cancel) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: state <= MD_ST_IDLE;
            endcase
        end
    end

endmodule
